int_dispatcher: RTL and testbench

Interrupt dispatcher that shares a pool of interrupt sources among several processors. It counts pending requests per source. It picks the next enabled source round-robin and offers it to an idle processor. It then tracks the ack/RETI handshake so that a source is never serviced by two processors at once. It sits between the interrupt units and the multi-processor manager, and supersedes per-processor hard-wired request buffers.

---
 rtl/int_dispatcher.sv | 153 +++++++++++++++
 tb/tb_int_dispatcher.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/int_dispatcher.sv
// Interrupt dispatcher: per-source pending counters, round-robin source selection
// and a per-CPU offer/ack/RETI handshake so that no source is ever serviced twice at once.
module int_dispatcher #(
  parameter int NUM_SRC   = 3,
  parameter int NUM_CPU   = 3,
  parameter int CNT_WIDTH = 5,
  localparam int SRC_W    = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       int_req,
  input  logic [NUM_SRC-1:0]       int_enable,
  output logic [NUM_CPU-1:0]       cpu_flag,
  output logic [NUM_CPU*SRC_W-1:0] cpu_vector,
  input  logic [NUM_CPU-1:0]       cpu_ack,
  input  logic [NUM_CPU-1:0]       cpu_reti,
  output logic [NUM_SRC-1:0]       src_busy,
  output logic [NUM_SRC-1:0]       overflow
);

  typedef enum logic [1:0] {IDLE, OFFER, HANDLING} state_e;

  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

  logic [CNT_WIDTH-1:0] pend_q [NUM_SRC];
  logic [NUM_SRC-1:0]   overflow_q;
  logic [NUM_SRC-1:0]   busy;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   dec;

  state_e               state_q [NUM_CPU];
  logic [SRC_W-1:0]     vec_q   [NUM_CPU];
  logic [NUM_CPU-1:0]   flag_q;
  logic [NUM_CPU-1:0]   grant;
  logic                 idle_seen;

  logic [SRC_W-1:0]     rr_q, rr_d;
  logic [SRC_W-1:0]     win_src, cand;
  logic                 win_valid;

  // A source is busy while any non-idle CPU holds it in its vector.
  always_comb begin
    busy = '0;
    dec  = '0;
    for (int c = 0; c < NUM_CPU; c++) begin
      if (state_q[c] != IDLE) busy[vec_q[c]] = 1'b1;
      if (state_q[c] == OFFER && cpu_ack[c]) dec[vec_q[c]] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_q[gi]     <= '0;
          overflow_q[gi] <= 1'b0;
        end else begin
          case ({int_req[gi], dec[gi]})
            2'b10: begin
              if (pend_q[gi] == PEND_MAX) overflow_q[gi] <= 1'b1;
              else                        pend_q[gi] <= pend_q[gi] + 1'b1;
            end
            2'b01:   pend_q[gi] <= pend_q[gi] - 1'b1;
            default: pend_q[gi] <= pend_q[gi];
          endcase
        end
      end

      assign elig[gi] = (pend_q[gi] != '0) && int_enable[gi] && !busy[gi];
    end
  endgenerate

  always_comb begin
    win_src   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((int'(rr_q) + i) % NUM_SRC);
      if (!win_valid && elig[cand]) begin
        win_src   = cand;
        win_valid = 1'b1;
      end
    end
  end

  // Only the lowest-index idle CPU can receive this cycle's single offer.
  always_comb begin
    grant     = '0;
    idle_seen = 1'b0;
    for (int c = 0; c < NUM_CPU; c++) begin
      if (!idle_seen && state_q[c] == IDLE) begin
        grant[c]  = win_valid;
        idle_seen = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (|grant) rr_d = (win_src == SRC_W'(NUM_SRC - 1)) ? '0 : win_src + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  generate
    for (genvar gi = 0; gi < NUM_CPU; gi++) begin : g_cpu
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q[gi] <= IDLE;
          vec_q[gi]   <= '0;
          flag_q[gi]  <= 1'b0;
        end else begin
          case (state_q[gi])
            IDLE: begin
              if (grant[gi]) begin
                state_q[gi] <= OFFER;
                vec_q[gi]   <= win_src;
                flag_q[gi]  <= 1'b1;
              end
            end
            OFFER: begin
              // An ack in the same cycle as a disable takes precedence.
              if (cpu_ack[gi]) begin
                state_q[gi] <= HANDLING;
                flag_q[gi]  <= 1'b0;
              end else if (!int_enable[vec_q[gi]]) begin
                state_q[gi] <= IDLE;
                flag_q[gi]  <= 1'b0;
              end
            end
            HANDLING: begin
              if (cpu_reti[gi]) state_q[gi] <= IDLE;
            end
            default: begin
              state_q[gi] <= IDLE;
              flag_q[gi]  <= 1'b0;
            end
          endcase
        end
      end

      assign cpu_vector[gi*SRC_W +: SRC_W] = vec_q[gi];
    end
  endgenerate

  assign cpu_flag = flag_q;
  assign src_busy = busy;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_int_dispatcher.sv
// Directed bench for int_dispatcher: 3 sources, 3 CPUs, 2-bit pending counters.
module tb_int_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] int_req, int_enable, cpu_ack, cpu_reti;
  logic [2:0] cpu_flag, src_busy, overflow;
  logic [5:0] cpu_vector;

  int n_pass  = 0;
  int n_total = 0;

  int_dispatcher #(.NUM_SRC(3), .NUM_CPU(3), .CNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .int_req    (int_req),
    .int_enable (int_enable),
    .cpu_flag   (cpu_flag),
    .cpu_vector (cpu_vector),
    .cpu_ack    (cpu_ack),
    .cpu_reti   (cpu_reti),
    .src_busy   (src_busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-18s got=%0h", tag, got);
    end else begin
      $display("FAIL %-18s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; int_req = '0; cpu_ack = '0; cpu_reti = '0; int_enable = 3'b111;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_flag", cpu_flag, 3'b000);
    check("rst_vector", cpu_vector, 6'd0);
    check("rst_busy", src_busy, 3'b000);
    check("rst_ovf", overflow, 3'b000);

    // Basic path on source 1
    int_req = 3'b010; step(); int_req = '0;
    check("basic_nolat", cpu_flag, 3'b000);
    step();
    check("basic_flag", cpu_flag, 3'b001);
    check("basic_vec0", cpu_vector[1:0], 2'd1);
    check("basic_busy", src_busy, 3'b010);
    cpu_ack = 3'b001; step(); cpu_ack = '0;
    check("basic_ackflag", cpu_flag, 3'b000);
    check("basic_ackbusy", src_busy, 3'b010);
    step();
    check("basic_hold", cpu_flag, 3'b000);
    cpu_reti = 3'b001; step(); cpu_reti = '0;
    check("basic_reti", src_busy, 3'b000);
    check("basic_veckeep", cpu_vector[1:0], 2'd1);
    step();
    check("basic_pend0", cpu_flag, 3'b000);

    // Round-robin across all three CPUs
    do_reset();
    int_req = 3'b111; step(); int_req = '0;
    check("rr_nolat", cpu_flag, 3'b000);
    step();
    check("rr_off0", {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd0});
    step();
    check("rr_off1", {cpu_flag, cpu_vector[3:2]}, {3'b011, 2'd1});
    step();
    check("rr_off2", cpu_flag, 3'b111);
    check("rr_vec", cpu_vector, 6'b10_01_00);
    check("rr_busy", src_busy, 3'b111);
    cpu_ack = 3'b111; step(); cpu_ack = '0;
    check("rr_ack", cpu_flag, 3'b000);
    cpu_reti = 3'b111; step(); cpu_reti = '0;
    check("rr_reti", src_busy, 3'b000);
    int_req = 3'b110; step(); int_req = '0;
    step();
    check("rr_ptr0_src1", {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd1});
    step();
    check("rr_next_src2", {cpu_flag, cpu_vector[3:2]}, {3'b011, 2'd2});

    // Serialisation: three requests on source 2
    do_reset();
    int_req = 3'b100; step(); step(); step(); int_req = '0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ser_offer%0d", k), {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd2});
      cpu_ack = 3'b001; step(); cpu_ack = '0;
      check($sformatf("ser_ack%0d", k), cpu_flag, 3'b000);
      step();
      check($sformatf("ser_nodup%0d", k), cpu_flag, 3'b000);
      cpu_reti = 3'b001; step(); cpu_reti = '0;
      check($sformatf("ser_free%0d", k), src_busy, 3'b000);
      step();
    end
    check("ser_drained", cpu_flag, 3'b000);

    // Withdrawal, then ack beating a simultaneous disable
    do_reset();
    int_req = 3'b001; step(); int_req = '0; step();
    check("wd_offer", {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd0});
    int_enable = 3'b110; step();
    check("wd_flag", cpu_flag, 3'b000);
    check("wd_busy", src_busy, 3'b000);
    int_enable = 3'b111; step();
    check("wd_reoffer", {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd0});
    int_enable = 3'b110; cpu_ack = 3'b001; step(); cpu_ack = '0;
    check("wd_ackwins", {cpu_flag, src_busy}, {3'b000, 3'b001});
    int_enable = 3'b111; cpu_reti = 3'b001; step(); cpu_reti = '0;
    step();
    check("wd_pend0", cpu_flag, 3'b000);

    // Saturation with 2-bit counters, and req+ack in the same cycle
    do_reset();
    int_enable = 3'b101;
    int_req = 3'b010; step(); step(); step(); step(); int_req = '0;
    check("sat_ovf", overflow, 3'b010);
    check("sat_disabled", cpu_flag, 3'b000);
    int_enable = 3'b111; step();
    check("sat_offer", {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd1});
    cpu_ack = 3'b001; int_req = 3'b010; step(); cpu_ack = '0; int_req = '0;
    cpu_reti = 3'b001; step(); cpu_reti = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("sat_re%0d", k), {cpu_flag, cpu_vector[1:0]}, {3'b001, 2'd1});
      cpu_ack = 3'b001; step(); cpu_ack = '0;
      cpu_reti = 3'b001; step(); cpu_reti = '0;
    end
    step();
    check("sat_drained", cpu_flag, 3'b000);
    check("sat_sticky", overflow, 3'b010);

    // Reset while CPU1 is handling source 0 with pend[0]=2
    do_reset();
    check("rst_ovfclr", overflow, 3'b000);
    int_req = 3'b010; step(); int_req = '0; step();
    cpu_ack = 3'b001; step(); cpu_ack = '0;
    int_req = 3'b001; step(); step(); step(); int_req = '0;
    check("mid_offer1", {cpu_flag, cpu_vector[3:2]}, {3'b010, 2'd0});
    cpu_ack = 3'b010; step(); cpu_ack = '0;
    check("mid_busy", src_busy, 3'b011);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst", {cpu_flag, cpu_vector, src_busy, overflow}, 15'd0);
    cpu_reti = 3'b010; step(); cpu_reti = '0;
    step(); step();
    check("mid_lost", {cpu_flag, src_busy}, 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
